btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//   Conditions one raw mechanical push-button into clean single-cycle press events.
//   Sits directly upstream of the debug state stepper and drives its btn input with btn_pulse.
//   Contains a 2-FF synchroniser, a 4-state debounce FSM, a one-shot press pulse and a long-press detector.
// PARAMETERS
//   DEBOUNCE_CYC  500000    stable cycles required to accept a press/release (10 ms @ 50 MHz); >=2
//   LONG_CYC      50000000  cycles held in PRESSED before btn_long fires (1 s @ 50 MHz); >DEBOUNCE_CYC
//   REPEAT_PER    10000000  auto-repeat period in cycles (used only with BTN_AUTOREPEAT_EN); >=2
//   CNT_W         26        counter width; must hold max(DEBOUNCE_CYC, LONG_CYC, REPEAT_PER)
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst_n      in   1  asynchronous active-low reset
//   btn_raw    in   1  raw asynchronous button, active-high, bouncy
//   btn_level  out  1  debounced level, 1 while press accepted
//   btn_pulse  out  1  one-cycle pulse per accepted press (plus repeats, see CONFIGURATION)
//   btn_long   out  1  one-cycle pulse once per press when hold reaches LONG_CYC
//   fsm_state  out  2  current FSM state code, for debug LEDs
// BEHAVIOUR
//   Reset (async, rst_n=0): sync FFs=0, state=IDLE, all counters=0, btn_level=0, btn_pulse=0, btn_long=0, fsm_state=0.
//   Sync: s1<=btn_raw, s2<=s1; FSM sees only s2 (btn_sync). 2-cycle sync latency.
//   States/codes: IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3.
//   IDLE: btn_sync=1 -> PRESS_WAIT, dcnt<=0.
//   PRESS_WAIT: btn_sync=0 -> IDLE (bounce rejected, no output).
//     else if dcnt==DEBOUNCE_CYC-1 -> PRESSED, btn_level<=1, btn_pulse<=1, hcnt<=0; else dcnt++.
//   PRESSED: btn_sync=0 -> RELEASE_WAIT, dcnt<=0. else hcnt++ saturating at LONG_CYC;
//     btn_long<=1 on the single cycle hcnt transitions LONG_CYC-1 -> LONG_CYC.
//   RELEASE_WAIT: btn_sync=1 -> PRESSED (release bounce; hcnt kept, no new pulse).
//     else if dcnt==DEBOUNCE_CYC-1 -> IDLE, btn_level<=0; else dcnt++. hcnt frozen here.
//   Latency: btn_raw steady 1, edge 1 = first edge sampling 1 -> btn_pulse high after edge DEBOUNCE_CYC+3,
//     for exactly one cycle. Release: btn_level falls after edge DEBOUNCE_CYC+3 of a steady 0.
//   All outputs registered; btn_pulse and btn_long default to 0 every cycle unless set above.
//   btn_pulse and btn_long may be high in the same cycle only via auto-repeat (see below).
//   Illegal state encodings cannot occur (2-bit, 4 states); default branch -> IDLE, outputs cleared.
//   Reset mid-press: all state lost, no pulse emitted; re-press needs full debounce after rst_n rises.
//   Button held through reset release: treated as a new press (pulse after DEBOUNCE_CYC+3 edges).
// CONFIGURATION
//   BTN_AUTOREPEAT_EN defined: adds rcnt. On the cycle btn_long fires, btn_pulse also fires and rcnt<=0;
//     thereafter while in PRESSED and hcnt==LONG_CYC, rcnt++, and when rcnt==REPEAT_PER-1 btn_pulse<=1, rcnt<=0.
//     rcnt frozen in RELEASE_WAIT, cleared on entry to PRESSED from PRESS_WAIT.
//   Not defined: rcnt absent; exactly one btn_pulse per accepted press; REPEAT_PER unused.
// TESTING  (DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_PER=5, CNT_W=8)
//   1 rst_n=0 with btn_raw=1 -> all outputs 0, fsm_state=0 throughout reset.
//   2 btn_raw 0->1 steady -> btn_pulse=1 for one cycle after edge 7, btn_level=1 same cycle, fsm_state=2.
//   3 btn_raw pulses 1 for 3 cycles then 0 -> fsm_state visits 1 then returns to 0; btn_pulse never 1.
//   4 hold 30 cycles past pulse, macro off -> btn_long once 20 cycles after pulse; no further pulses.
//   5 macro on, hold -> btn_pulse at press, at btn_long cycle, then every 5 cycles until release.
//   6 release with 2-cycle 1-glitch mid RELEASE_WAIT -> back to PRESSED, no pulse; level falls after 4 stable 0s.

Source files
------------

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - push-button synchroniser, debounce FSM, press pulse and long-press detector
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat press pulses while held past LONG_CYC)
module btn_conditioner #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_PER   = 10000000,
  parameter int CNT_W        = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       btn_pulse,
  output logic       btn_long,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYC);

  // Reject parameter sets the counters cannot represent or the FSM cannot honour.
  if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC || REPEAT_PER < 2 ||
      CNT_W < 2 || CNT_W > 31 || LONG_CYC >= (1 << CNT_W) ||
      REPEAT_PER >= (1 << CNT_W)) begin : g_param_check
    $error("btn_conditioner: illegal parameter combination");
  end

  state_t           state;
  logic             s1;
  logic             s2;
  logic             btn_sync;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] hcnt;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_PER - 1);
  logic [CNT_W-1:0] rcnt;
`endif

  // Two-flop synchroniser; the FSM only ever looks at the second stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  assign btn_sync  = s2;
  assign fsm_state = state;

  // Debounce FSM with hold/repeat counters and registered level/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dcnt      <= '0;
      hcnt      <= '0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
      btn_long  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rcnt      <= '0;
`endif
    end else begin
      btn_pulse <= 1'b0;
      btn_long  <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_sync) begin
            state <= PRESS_WAIT;
            dcnt  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync) begin
            state <= IDLE;
          end else if (dcnt == DEB_LAST) begin
            state     <= PRESSED;
            btn_level <= 1'b1;
            btn_pulse <= 1'b1;
            hcnt      <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt      <= '0;
`endif
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_sync) begin
            state <= RELEASE_WAIT;
            dcnt  <= '0;
          end else if (hcnt < LONG_MAX) begin
            hcnt <= hcnt + 1'b1;
            if (hcnt == LONG_LAST) begin
              btn_long  <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              btn_pulse <= 1'b1;
              rcnt      <= '0;
`endif
            end
`ifdef BTN_AUTOREPEAT_EN
          end else if (rcnt == REP_LAST) begin
            btn_pulse <= 1'b1;
            rcnt      <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
`endif
          end
        end
        RELEASE_WAIT: begin
          // A return to 1 here is release bounce: resume the hold without a new pulse.
          if (btn_sync) begin
            state <= PRESSED;
          end else if (dcnt == DEB_LAST) begin
            state     <= IDLE;
            btn_level <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - randomized self-checking bench for btn_conditioner
module tb_btn_conditioner;

  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 5;
  localparam int W   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       btn_level;
  logic       btn_pulse;
  logic       btn_long;
  logic [1:0] fsm_state;

  int n_pass = 0;
  int n_total = 0;
  int edge_n = 0;

  // Reference model: accepted level flips after DEB+1 consecutive synchronised
  // samples disagreeing with it; hold time counts steady-held samples.
  bit m_s1, m_s2, m_prev, m_lvl, m_pulse, m_long;
  int m_run, m_hold, m_rep;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC(LNG),
    .REPEAT_PER(REP),
    .CNT_W(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .btn_long(btn_long),
    .fsm_state(fsm_state)
  );

  function automatic logic [4:0] exp_vec();
    logic [1:0] st;
    if (m_lvl) st = (m_run > 0) ? 2'd3 : 2'd2;
    else       st = (m_run > 0) ? 2'd1 : 2'd0;
    return {m_lvl, m_pulse, m_long, st};
  endfunction

  function automatic logic [4:0] act_vec();
    return {btn_level, btn_pulse, btn_long, fsm_state};
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_prev = 0; m_lvl = 0; m_pulse = 0; m_long = 0;
    m_run = 0; m_hold = 0; m_rep = 0;
  endtask

  // Drive one raw sample, advance one rising edge, update the model, settle.
  task automatic cycle(input bit v);
    bit sy;
    btn_raw = v;
    @(posedge clk);
    edge_n++;
    sy = m_s2;
    m_s2 = m_s1;
    m_s1 = v;
    m_pulse = 0;
    m_long = 0;
    if (sy != m_lvl) m_run++;
    else m_run = 0;
    if (m_run == DEB + 1) begin
      m_lvl = ~m_lvl;
      m_run = 0;
      if (m_lvl) begin
        m_pulse = 1;
        m_hold = 0;
        m_rep = 0;
      end
    end else if (m_lvl && sy && m_prev) begin
      if (m_hold < LNG) begin
        m_hold++;
        if (m_hold == LNG) begin
          m_long = 1;
`ifdef BTN_AUTOREPEAT_EN
          m_pulse = 1;
          m_rep = 0;
`endif
        end
      end else begin
`ifdef BTN_AUTOREPEAT_EN
        m_rep++;
        if (m_rep == REP) begin
          m_pulse = 1;
          m_rep = 0;
        end
`endif
      end
    end
    m_prev = sy;
    #1;
  endtask

  // Assert reset for n cycles, checking outputs stay cleared, release on a falling edge.
  task automatic apply_reset(input int n, input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i <= n; i++) begin
      n_total++;
      if (act_vec() !== 5'b0) $display("FAIL %s_in_reset i=%0d got=%b exp=%b", tag, i, act_vec(), 5'b0);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int pe;
    int np;
    btn_raw = 1'b1;
    apply_reset(5, "reset");
    pe = -1;
    np = 0;
    for (int i = 1; i <= 14; i++) begin
      cycle(1'b1);
      n_total++;
      if (act_vec() !== exp_vec()) $display("FAIL reset_hold i=%0d got=%b exp=%b", i, act_vec(), exp_vec());
      else n_pass++;
      if (btn_pulse) begin
        np++;
        if (pe < 0) pe = i;
      end
    end
    n_total++;
    if (pe !== DEB + 3 || np !== 1) $display("FAIL reset_held_press edge=%0d cnt=%0d exp edge=%0d cnt=1", pe, np, DEB + 3);
    else n_pass++;
  endtask

  task automatic test_press_release();
    int fe;
    int pe;
    fe = -1;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0);
      n_total++;
      if (act_vec() !== exp_vec()) $display("FAIL release i=%0d got=%b exp=%b", i, act_vec(), exp_vec());
      else n_pass++;
      if (!btn_level && fe < 0) fe = i;
    end
    n_total++;
    if (fe !== DEB + 3) $display("FAIL release_latency got=%0d exp=%0d", fe, DEB + 3);
    else n_pass++;
    pe = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1);
      n_total++;
      if (act_vec() !== exp_vec()) $display("FAIL press i=%0d got=%b exp=%b", i, act_vec(), exp_vec());
      else n_pass++;
      if (btn_pulse && pe < 0) pe = i;
    end
    n_total++;
    if (pe !== DEB + 3 || btn_level !== 1'b1 || fsm_state !== 2'd2)
      $display("FAIL press_latency edge=%0d lvl=%b st=%0d exp edge=%0d lvl=1 st=2", pe, btn_level, fsm_state, DEB + 3);
    else n_pass++;
    for (int i = 0; i < 12; i++) cycle(1'b0);
  endtask

  task automatic test_bounce();
    bit saw1;
    bit anyp;
    saw1 = 0;
    anyp = 0;
    for (int i = 1; i <= 14; i++) begin
      cycle(i <= 3);
      n_total++;
      if (act_vec() !== exp_vec()) $display("FAIL bounce i=%0d got=%b exp=%b", i, act_vec(), exp_vec());
      else n_pass++;
      if (fsm_state == 2'd1) saw1 = 1;
      if (btn_pulse) anyp = 1;
    end
    n_total++;
    if (!saw1 || anyp || fsm_state !== 2'd0)
      $display("FAIL bounce_summary saw1=%b pulse=%b st=%0d exp saw1=1 pulse=0 st=0", saw1, anyp, fsm_state);
    else n_pass++;
  endtask

  task automatic test_long_hold();
    int pe;
    int le;
    int nl;
    int np;
    pe = -1;
    le = -1;
    nl = 0;
    np = 0;
    for (int i = 1; i <= DEB + 3 + 45; i++) begin
      cycle(1'b1);
      n_total++;
      if (act_vec() !== exp_vec()) $display("FAIL long_hold i=%0d got=%b exp=%b", i, act_vec(), exp_vec());
      else n_pass++;
      if (btn_pulse) begin
        np++;
        if (pe < 0) pe = i;
      end
      if (btn_long) begin
        nl++;
        if (le < 0) le = i;
      end
    end
    n_total++;
    if (nl !== 1 || le - pe !== LNG) $display("FAIL long_timing cnt=%0d dist=%0d exp cnt=1 dist=%0d", nl, le - pe, LNG);
    else n_pass++;
    n_total++;
`ifdef BTN_AUTOREPEAT_EN
    if (np !== 2 + (DEB + 3 + 45 - le) / REP) $display("FAIL repeat_count got=%0d exp=%0d", np, 2 + (DEB + 3 + 45 - le) / REP);
    else n_pass++;
`else
    if (np !== 1) $display("FAIL single_pulse got=%0d exp=1", np);
    else n_pass++;
`endif
  endtask

  task automatic test_release_glitch();
    bit saw3;
    bit back2;
    bit anyp;
    saw3 = 0;
    back2 = 0;
    anyp = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle((i == 3 || i == 4) ? 1'b1 : 1'b0);
      n_total++;
      if (act_vec() !== exp_vec()) $display("FAIL rel_glitch i=%0d got=%b exp=%b", i, act_vec(), exp_vec());
      else n_pass++;
      if (fsm_state == 2'd3) saw3 = 1;
      if (saw3 && fsm_state == 2'd2) back2 = 1;
      if (btn_pulse) anyp = 1;
    end
    n_total++;
    if (!saw3 || !back2 || anyp || btn_level !== 1'b0)
      $display("FAIL rel_glitch_summary saw3=%b back2=%b pulse=%b lvl=%b exp 1 1 0 0", saw3, back2, anyp, btn_level);
    else n_pass++;
  endtask

  task automatic test_random();
    bit v;
    int len;
    v = 0;
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 29) == 0) apply_reset($urandom_range(1, 3), "rand");
      v = ~v;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        cycle(v);
        n_total++;
        if (act_vec() !== exp_vec()) $display("FAIL random seg=%0d i=%0d got=%b exp=%b", s, i, act_vec(), exp_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_release();
    test_bounce();
    test_long_hold();
    test_release_glitch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
